// File: rtl/tl_arb2.sv
// tl_arb2: two-master round-robin arbiter feeding one single-beat TileLink slave.
// Only one transaction is outstanding; the D response is routed back to its requester.
package tl_pkg;
    localparam int AW = 64;
    localparam int DW = 64;
    typedef struct packed {
        logic [2:0]      opcode;
        logic [2:0]      param;
        logic [2:0]      size;
        logic [3:0]      source;
        logic [AW-1:0]   address;
        logic [DW/8-1:0] mask;
        logic [DW-1:0]   data;
        logic            corrupt;
    } A_chan_bits_t;
    typedef struct packed {
        logic [2:0]    opcode;
        logic [1:0]    param;
        logic [2:0]    size;
        logic [3:0]    source;
        logic          sink;
        logic          denied;
        logic [DW-1:0] data;
        logic          corrupt;
    } D_chan_bits_t;
endpackage

module tl_arb2 #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 m0_A_valid_i,
    output logic                 m0_A_ready_o,
    input  tl_pkg::A_chan_bits_t m0_A_bits_i,
    output logic                 m0_D_valid_o,
    input  logic                 m0_D_ready_i,
    output tl_pkg::D_chan_bits_t m0_D_bits_o,
    input  logic                 m1_A_valid_i,
    output logic                 m1_A_ready_o,
    input  tl_pkg::A_chan_bits_t m1_A_bits_i,
    output logic                 m1_D_valid_o,
    input  logic                 m1_D_ready_i,
    output tl_pkg::D_chan_bits_t m1_D_bits_o,
    output logic                 s_A_valid_o,
    input  logic                 s_A_ready_i,
    output tl_pkg::A_chan_bits_t s_A_bits_o,
    input  logic                 s_D_valid_i,
    output logic                 s_D_ready_o,
    input  tl_pkg::D_chan_bits_t s_D_bits_i,
    output logic                 busy_o
);
    // The channel structs are sized by the package, so the parameters must agree with it.
    if (ADDR_WIDTH != tl_pkg::AW || DATA_WIDTH != tl_pkg::DW) begin : g_width_check
        $error("tl_arb2: ADDR_WIDTH/DATA_WIDTH must match tl_pkg");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT_D} state_t;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 gnt_q, gnt_d;
    tl_pkg::A_chan_bits_t req_q, req_d;
    logic                 any_valid;
    logic                 win;
    logic                 d_ready;

    assign any_valid = m0_A_valid_i | m1_A_valid_i;
    // Tie goes to prio_q; otherwise the single valid master wins.
    assign win = (m0_A_valid_i & m1_A_valid_i) ? prio_q : m1_A_valid_i;
    assign d_ready = gnt_q ? m1_D_ready_i : m0_D_ready_i;

    assign s_A_bits_o  = req_q;
    assign m0_D_bits_o = s_D_bits_i;
    assign m1_D_bits_o = s_D_bits_i;
    assign busy_o      = state_q != IDLE;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        gnt_d        = gnt_q;
        req_d        = req_q;
        m0_A_ready_o = 1'b0;
        m1_A_ready_o = 1'b0;
        s_A_valid_o  = 1'b0;
        s_D_ready_o  = 1'b0;
        m0_D_valid_o = 1'b0;
        m1_D_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is gated by reset so nothing handshakes while reset is held.
                if (rst_i && any_valid) begin
                    m0_A_ready_o = !win;
                    m1_A_ready_o = win;
                    req_d        = win ? m1_A_bits_i : m0_A_bits_i;
                    gnt_d        = win;
                    state_d      = SEND;
                end
            end
            SEND: begin
                s_A_valid_o = 1'b1;
                state_d     = s_A_ready_i ? WAIT_D : SEND;
            end
            WAIT_D: begin
                s_D_ready_o  = d_ready;
                m0_D_valid_o = !gnt_q & s_D_valid_i;
                m1_D_valid_o = gnt_q & s_D_valid_i;
                if (s_D_valid_i && d_ready) begin
                    state_d = IDLE;
                    prio_d  = !gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tl_arb2.sv
// tb_tl_arb2: directed stimulus with a transaction-level model checked every cycle.
module tb_tl_arb2;
    logic                 clk = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 m0v = 1'b0, m1v = 1'b0, m0r = 1'b0, m1r = 1'b0;
    logic                 s_ar = 1'b0, s_dv = 1'b0;
    tl_pkg::A_chan_bits_t m0_a = '0, m1_a = '0;
    tl_pkg::D_chan_bits_t s_d = '0;
    logic                 m0_ar, m1_ar, m0_dv, m1_dv, s_av, s_dr, busy;
    tl_pkg::A_chan_bits_t s_a;
    tl_pkg::D_chan_bits_t m0_d, m1_d;

    int checks = 0;
    int errors = 0;
    int grants[$];

    bit                   m_busy = 0, m_sent = 0, m_owner = 0, m_turn = 0;
    tl_pkg::A_chan_bits_t m_req = '0;
    logic                 e_ar0, e_ar1, dph;

    always #5 clk = ~clk;

    tl_arb2 dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_A_valid_i(m0v), .m0_A_ready_o(m0_ar), .m0_A_bits_i(m0_a),
        .m0_D_valid_o(m0_dv), .m0_D_ready_i(m0r), .m0_D_bits_o(m0_d),
        .m1_A_valid_i(m1v), .m1_A_ready_o(m1_ar), .m1_A_bits_i(m1_a),
        .m1_D_valid_o(m1_dv), .m1_D_ready_i(m1r), .m1_D_bits_o(m1_d),
        .s_A_valid_o(s_av), .s_A_ready_i(s_ar), .s_A_bits_o(s_a),
        .s_D_valid_i(s_dv), .s_D_ready_o(s_dr), .s_D_bits_i(s_d),
        .busy_o(busy)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic chk_a(input string n, input tl_pkg::A_chan_bits_t a, input tl_pkg::A_chan_bits_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic chk_d(input string n, input tl_pkg::D_chan_bits_t a, input tl_pkg::D_chan_bits_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic tl_pkg::A_chan_bits_t mk_a(input logic [2:0] op, input logic [63:0] addr, input logic [3:0] src);
        mk_a         = '0;
        mk_a.opcode  = op;
        mk_a.size    = 3'd3;
        mk_a.source  = src;
        mk_a.address = addr;
        mk_a.mask    = 8'hff;
    endfunction

    // Model: one outstanding transaction, owner known, A forwarded or not, turn for ties.
    initial forever begin
        @(negedge clk);
        if (!rst_i) begin
            m_busy = 0;
            m_sent = 0;
            m_turn = 0;
        end
        dph   = m_busy && m_sent;
        e_ar0 = rst_i && !m_busy && m0v && (!m1v || !m_turn);
        e_ar1 = rst_i && !m_busy && m1v && (!m0v || m_turn);
        chk("m0_A_ready", 64'(m0_ar), 64'(e_ar0));
        chk("m1_A_ready", 64'(m1_ar), 64'(e_ar1));
        chk("s_A_valid", 64'(s_av), 64'(m_busy && !m_sent));
        if (m_busy && !m_sent) chk_a("s_A_bits", s_a, m_req);
        chk("m0_D_valid", 64'(m0_dv), 64'(dph && !m_owner && s_dv));
        chk("m1_D_valid", 64'(m1_dv), 64'(dph && m_owner && s_dv));
        chk("s_D_ready", 64'(s_dr), 64'(dph && (m_owner ? m1r : m0r)));
        chk_d("m0_D_bits", m0_d, s_d);
        chk_d("m1_D_bits", m1_d, s_d);
        chk("busy", 64'(busy), 64'(m_busy));
        if (m0_ar && m0v) grants.push_back(0);
        if (m1_ar && m1v) grants.push_back(1);
        if (rst_i) begin
            if (!m_busy) begin
                if (m0v || m1v) begin
                    m_owner = (m0v && m1v) ? m_turn : m1v;
                    m_req   = m_owner ? m1_a : m0_a;
                    m_busy  = 1;
                    m_sent  = 0;
                end
            end else if (!m_sent) begin
                m_sent = s_ar;
            end else if (s_dv && (m_owner ? m1r : m0r)) begin
                m_busy = 0;
                m_turn = !m_owner;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int target);
        int k = 0;
        while (grants.size() < target && k < 50) begin
            step(1);
            k++;
        end
        if (grants.size() < target) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", grants.size(), target);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            step(1);
            k++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy still %0b expected 0", busy);
        end
    endtask

    initial begin
        int base;
        m0v = 1'b1;
        m1v = 1'b1;
        step(2);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_m0_A_ready", 64'(m0_ar), 64'd0);
        chk("reset_m1_A_ready", 64'(m1_ar), 64'd0);
        chk("reset_s_A_valid", 64'(s_av), 64'd0);
        m0v = 1'b0;
        m1v = 1'b0;
        rst_i = 1'b1;
        step(1);
        // single master Get
        m0_a = mk_a(3'd4, 64'h8000_0010, 4'd3);
        m0v = 1'b1;
        s_ar = 1'b1;
        m0r = 1'b1;
        m1r = 1'b1;
        step(1);
        m0v = 1'b0;
        chk("get_s_A_valid", 64'(s_av), 64'd1);
        chk("get_address", s_a.address, 64'h8000_0010);
        chk("get_source", 64'(s_a.source), 64'd3);
        step(1);
        s_d.opcode = 3'd1;
        s_d.source = 4'd3;
        s_d.data = 64'h1122_3344_5566_7788;
        s_dv = 1'b1;
        #1;
        chk("get_m0_D_valid", 64'(m0_dv), 64'd1);
        chk("get_m1_D_valid", 64'(m1_dv), 64'd0);
        chk("get_m0_D_data", m0_d.data, 64'h1122_3344_5566_7788);
        step(1);
        s_dv = 1'b0;
        chk("get_done_busy", 64'(busy), 64'd0);
        // spurious D in IDLE
        s_dv = 1'b1;
        #1;
        chk("spur_s_D_ready", 64'(s_dr), 64'd0);
        chk("spur_m0_D_valid", 64'(m0_dv), 64'd0);
        step(2);
        chk("spur_busy", 64'(busy), 64'd0);
        s_dv = 1'b0;
        // contention after reset, both held valid
        rst_i = 1'b0;
        step(1);
        rst_i = 1'b1;
        step(1);
        m0_a = mk_a(3'd4, 64'h0000_0100, 4'd1);
        m1_a = mk_a(3'd0, 64'h0000_0200, 4'd2);
        base = grants.size();
        m0v = 1'b1;
        m1v = 1'b1;
        s_dv = 1'b1;
        wait_grants(base + 4);
        m0v = 1'b0;
        m1v = 1'b0;
        wait_idle();
        s_dv = 1'b0;
        chk("rr_g0", 64'(grants[base]), 64'd0);
        chk("rr_g1", 64'(grants[base+1]), 64'd1);
        chk("rr_g2", 64'(grants[base+2]), 64'd0);
        chk("rr_g3", 64'(grants[base+3]), 64'd1);
        // slave A backpressure
        s_ar = 1'b0;
        m1_a = mk_a(3'd0, 64'h1000_0040, 4'd5);
        m1v = 1'b1;
        step(1);
        m0v = 1'b1;
        m1_a = mk_a(3'd0, 64'hdead_0000, 4'd6);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_s_A_valid", 64'(s_av), 64'd1);
            chk("bp_address", s_a.address, 64'h1000_0040);
            chk("bp_source", 64'(s_a.source), 64'd5);
            chk("bp_m0_A_ready", 64'(m0_ar), 64'd0);
            chk("bp_m1_A_ready", 64'(m1_ar), 64'd0);
            step(1);
        end
        s_ar = 1'b1;
        m0v = 1'b0;
        m1v = 1'b0;
        step(1);
        chk("bp_fwd_s_A_valid", 64'(s_av), 64'd0);
        chk("bp_fwd_busy", 64'(busy), 64'd1);
        // master D backpressure
        m1r = 1'b0;
        s_d.data = 64'h0bad_cafe_0000_0001;
        s_dv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dbp_s_D_ready", 64'(s_dr), 64'd0);
            chk("dbp_m1_D_valid", 64'(m1_dv), 64'd1);
            chk("dbp_busy", 64'(busy), 64'd1);
            step(1);
        end
        m1r = 1'b1;
        #1;
        chk("dbp_release_s_D_ready", 64'(s_dr), 64'd1);
        step(1);
        chk("dbp_done_busy", 64'(busy), 64'd0);
        base = grants.size();
        m0v = 1'b1;
        m1v = 1'b1;
        wait_grants(base + 1);
        m0v = 1'b0;
        m1v = 1'b0;
        wait_idle();
        chk("dbp_prio_m0", 64'(grants[base]), 64'd1 - 64'd1);
        // reset while the slave holds D valid in WAIT_D
        m0_a = mk_a(3'd4, 64'h2000_0008, 4'd1);
        m0v = 1'b1;
        step(1);
        m0v = 1'b0;
        wait_idle();
        m0r = 1'b0;
        m0v = 1'b1;
        step(1);
        m0v = 1'b0;
        step(1);
        #1;
        chk("rst_pre_busy", 64'(busy), 64'd1);
        chk("rst_pre_m0_D_valid", 64'(m0_dv), 64'd1);
        rst_i = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m0_D_valid", 64'(m0_dv), 64'd0);
        chk("rst_s_D_ready", 64'(s_dr), 64'd0);
        step(1);
        rst_i = 1'b1;
        m0r = 1'b1;
        step(2);
        chk("rst_after_busy", 64'(busy), 64'd0);
        base = grants.size();
        m0v = 1'b1;
        m1v = 1'b1;
        wait_grants(base + 1);
        m0v = 1'b0;
        m1v = 1'b0;
        wait_idle();
        s_dv = 1'b0;
        chk("rst_prio_m0", 64'(grants[base]), 64'd0);
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tl_arb2.md
TL_ARB2 -- requirements
Module: tl_arb2

Interface
REQ-001 SHALL: parameter ADDR_WIDTH, default 64, address width carried in the A-channel bits.
REQ-002 SHALL: parameter DATA_WIDTH, default 64, data width carried in the A- and D-channel bits.
REQ-003 SHALL: clk_i  input  1  single clock; all state on the rising edge.
REQ-004 SHALL: rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL: m0_A_valid_i / m0_A_ready_o / m0_A_bits_i  in/out/in  1/1/tl_pkg::A_chan_bits_t  master 0 A channel.
REQ-006 SHALL: m0_D_valid_o / m0_D_ready_i / m0_D_bits_o  out/in/out  1/1/tl_pkg::D_chan_bits_t  master 0 D channel.
REQ-007 SHALL: m1_A_valid_i / m1_A_ready_o / m1_A_bits_i  in/out/in  1/1/tl_pkg::A_chan_bits_t  master 1 A channel.
REQ-008 SHALL: m1_D_valid_o / m1_D_ready_i / m1_D_bits_o  out/in/out  1/1/tl_pkg::D_chan_bits_t  master 1 D channel.
REQ-009 SHALL: s_A_valid_o / s_A_ready_i / s_A_bits_o  out/in/out  1/1/tl_pkg::A_chan_bits_t  A channel to the single-beat slave (the TL-to-memory bridge).
REQ-010 SHALL: s_D_valid_i / s_D_ready_o / s_D_bits_i  in/out/in  1/1/tl_pkg::D_chan_bits_t  D channel from the slave.
REQ-011 SHALL: busy_o  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL: The FSM has states IDLE, SEND and WAIT_D, with exactly one transaction outstanding toward the slave at any time.
REQ-013 SHALL: Arbitration in IDLE follows these rules.
- Winner is the only valid master, if exactly one is valid.
- Winner is the master selected by prio_q, if both are valid.
- With no valid master, nothing happens.
REQ-014 SHALL: In IDLE with a winner:
- mX_A_ready_o of the winner is 1 and the loser's is 0.
- The winner's A bits are captured into req_q and the winner index into gnt_q.
- Next state is SEND.
REQ-015 SHALL: mX_A_ready_o is 0 in SEND and WAIT_D.
- A masters are backpressured without the bits being sampled.
REQ-016 SHALL: In SEND:
- s_A_valid_o=1 and s_A_bits_o=req_q, held stable until s_A_ready_i=1.
- The handshake moves the state to WAIT_D.
- A-path latency is exactly 1 cycle from master acceptance to s_A_valid_o.
REQ-017 SHALL: In WAIT_D, the D path is combinational and routed by gnt_q.
- m{gnt}_D_valid_o = s_D_valid_i.
- s_D_ready_o = m{gnt}_D_ready_i.
- The other master's D_valid is 0.
REQ-018 SHALL: m0_D_bits_o and m1_D_bits_o both equal s_D_bits_i unmodified in all states, including source, opcode and data.
REQ-019 SHALL: A D handshake in WAIT_D (s_D_valid_i & s_D_ready_o) moves the state to IDLE and sets prio_q to the opposite of gnt_q (round-robin).
REQ-020 SHALL: Outside WAIT_D, s_D_ready_o=0 and both mX_D_valid_o=0.
- A spurious s_D_valid_i is ignored and does not change state.
REQ-021 SHALL: s_A_valid_o is 0 outside SEND.
REQ-022 SHALL: Minimum transaction period is 3 cycles (IDLE accept, SEND, WAIT_D), given a slave with ready=1 and a same-cycle response.
REQ-023 SHALL: Master A channels are not inspected beyond the valid bit.
- Opcode, size and mask pass through unchanged in req_q.
REQ-024 SHALL: No master is starved.
- With both masters continuously valid, grants alternate 0,1,0,1...

Reset
REQ-025 SHALL: On rst_i=0, asynchronously: state=IDLE, prio_q=0 (master 0 priority), gnt_q=0, req_q=0.
REQ-026 SHALL: During reset, all valid/ready outputs and busy_o are 0.
REQ-027 SHALL: Reset asserted mid-transaction (SEND or WAIT_D) drops the pending request and any later slave response without routing it.
- The first cycle after deassertion is IDLE.

Verification
REQ-028 SHALL: Single master: m0 Get at address 0x8000_0010, source 3, slave ready=1 -> s_A_valid_o 1 cycle after acceptance with address 0x8000_0010 and source 3. D with data 0x1122334455667788 appears only on m0_D, and m1_D_valid_o stays 0.
REQ-029 SHALL: Contention after reset: m0 and m1 both valid in the same cycle -> m0 granted first and m1 second. With both kept valid, the grant sequence over 4 transactions is 0,1,0,1.
REQ-030 SHALL: Slave backpressure: s_A_ready_i=0 for 5 cycles in SEND -> s_A_bits_o stable and both mX_A_ready_o=0 throughout. Forwarding completes in the first cycle s_A_ready_i=1.
REQ-031 SHALL: Master D backpressure: m1_D_ready_i=0 for 4 cycles with s_D_valid_i=1 -> s_D_ready_o=0 and state stays WAIT_D. On m1 ready, the handshake completes and prio_q becomes 0.
REQ-032 SHALL: Spurious D: s_D_valid_i=1 in IDLE -> s_D_ready_o=0, no mX_D_valid_o, no state change.
REQ-033 SHALL: Reset in WAIT_D: assert rst_i=0 for 1 cycle while the slave holds D valid -> busy_o=0 immediately, no D delivered to either master, prio_q=0.
